// File: rtl/result_mux_hilo.sv
// Result select for ALU/shifter/HI-LO with a multi-cycle external multiply; 1-cycle result latency.
// HI/LO accesses and new multiplies stall while busy; optional MTHI/MTLO under RESULT_MUX_MTHI_EN.
module result_mux_hilo #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [WIDTH-1:0] shift_out,
    input  logic [WIDTH-1:0] rs_data,
    output logic             mul_start,
    input  logic [WIDTH-1:0] mul_hi,
    input  logic [WIDTH-1:0] mul_lo,
    output logic             out_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             busy
);

    localparam int CW = $clog2(MUL_CYCLES + 1);

    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
`ifdef RESULT_MUX_MTHI_EN
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;
`endif

    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [CW-1:0]    cnt;
    logic             hilo_op;
    logic             accept;

    // Anything that reads or writes HI/LO, or starts a new multiply, must wait out the current one.
    always_comb begin
        hilo_op = 1'b0;
        case (funct)
            F_MULTU, F_MFHI, F_MFLO: hilo_op = 1'b1;
`ifdef RESULT_MUX_MTHI_EN
            F_MTHI, F_MTLO:          hilo_op = 1'b1;
`endif
            default:                 hilo_op = 1'b0;
        endcase
    end

    assign in_ready = !(busy && hilo_op);
    assign accept   = in_valid && in_ready;

`ifndef RESULT_MUX_MTHI_EN
    logic unused_rs;
    assign unused_rs = ^rs_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            hi        <= '0;
            lo        <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            mul_start <= 1'b0;
            out_valid <= 1'b0;
            data_out  <= '0;
        end else begin
            mul_start <= 1'b0;
            out_valid <= 1'b0;

            if (busy) begin
                if (cnt == '0) begin
                    hi   <= mul_hi;
                    lo   <= mul_lo;
                    busy <= 1'b0;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end

            // HI/LO writers below are only accepted when not busy, so they never collide with completion.
            if (accept) begin
                case (funct)
                    F_AND, F_OR, F_ADD, F_SUB, F_SLT: begin
                        out_valid <= 1'b1;
                        data_out  <= alu_out;
                    end
                    F_SLL: begin
                        out_valid <= 1'b1;
                        data_out  <= shift_out;
                    end
                    F_MFHI: begin
                        out_valid <= 1'b1;
                        data_out  <= hi;
                    end
                    F_MFLO: begin
                        out_valid <= 1'b1;
                        data_out  <= lo;
                    end
                    F_MULTU: begin
                        mul_start <= 1'b1;
                        busy      <= 1'b1;
                        cnt       <= CW'(MUL_CYCLES - 1);
                    end
`ifdef RESULT_MUX_MTHI_EN
                    F_MTHI: hi <= rs_data;
                    F_MTLO: lo <= rs_data;
`endif
                    default: begin
                        out_valid <= 1'b1;
                        data_out  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_result_mux_hilo.sv
// Scoreboard bench for result_mux_hilo (WIDTH=32, MUL_CYCLES=4).
// Stimulus pushes expected results; a negedge monitor pops and compares on out_valid.
module tb_result_mux_hilo;

    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  funct;
    logic [31:0] alu_out;
    logic [31:0] shift_out;
    logic [31:0] rs_data;
    logic        mul_start;
    logic [31:0] mul_hi;
    logic [31:0] mul_lo;
    logic        out_valid;
    logic [31:0] data_out;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] exp_q[$];

    result_mux_hilo #(.WIDTH(32), .MUL_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .funct(funct), .alu_out(alu_out), .shift_out(shift_out), .rs_data(rs_data),
        .mul_start(mul_start), .mul_hi(mul_hi), .mul_lo(mul_lo),
        .out_valid(out_valid), .data_out(data_out), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every presented result must match the oldest expected one.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_out_valid: got data %h expected no result", data_out);
                end else begin
                    chk("data_out", data_out, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic op(input logic [5:0] f, input logic [31:0] alu, input logic [31:0] sh,
                      input logic [31:0] rs, input logic [31:0] exp);
        funct = f; alu_out = alu; shift_out = sh; rs_data = rs; in_valid = 1'b1;
        @(negedge clk);
        chk("in_ready_op", {31'b0, in_ready}, 32'd1);
        exp_q.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic op_nores(input logic [5:0] f, input logic [31:0] rs);
        funct = f; rs_data = rs; in_valid = 1'b1;
        @(negedge clk);
        chk("in_ready_nores", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; funct = F_MFHI;
        alu_out = '0; shift_out = '0; rs_data = '0; mul_hi = '0; mul_lo = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_mul_start", {31'b0, mul_start}, 32'd0);
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Plain ALU/shift results
        op(F_ADD, 32'h0000_1234, 32'h0, 32'h0, 32'h0000_1234);
        op(F_SLL, 32'hFFFF_FFFF, 32'h0000_0008, 32'h0, 32'h0000_0008);
        op(F_AND, 32'h0F0F_0000, 32'h1, 32'h0, 32'h0F0F_0000);
        op(F_OR,  32'hA5A5_A5A5, 32'h2, 32'h0, 32'hA5A5_A5A5);
        op(F_SLT, 32'h0000_0001, 32'h3, 32'h0, 32'h0000_0001);
        op(6'b111111, 32'h1234_5678, 32'h9, 32'h0, 32'h0);
        idle(2);
        chk("hold_data_out", data_out, 32'h0);
        op(F_SUB, 32'h0000_00AB, 32'h0, 32'h0, 32'h0000_00AB);
        idle(2);
        chk("hold_data_out2", data_out, 32'h0000_00AB);
        chk("idle_out_valid", {31'b0, out_valid}, 32'd0);

        // MULTU then MFHI held: busy cycles 1-4, MFHI accepted cycle 5
        op_nores(F_MULTU, 32'h0);
        funct = F_MFHI; in_valid = 1'b1; mul_hi = 32'h1111_1111; mul_lo = 32'h2222_2222;
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) begin
                mul_hi = 32'hDEAD_BEEF;
                mul_lo = 32'h1234_5678;
            end
            @(negedge clk);
            chk($sformatf("mul_busy_c%0d", i), {31'b0, busy}, 32'd1);
            chk($sformatf("mul_rdy_c%0d", i), {31'b0, in_ready}, 32'd0);
            chk($sformatf("mul_start_c%0d", i), {31'b0, mul_start}, (i == 1) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
        end
        mul_hi = 32'hFFFF_FFFF; mul_lo = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("mul_busy_c5", {31'b0, busy}, 32'd0);
        chk("mul_rdy_c5", {31'b0, in_ready}, 32'd1);
        exp_q.push_back(32'hDEAD_BEEF);
        @(posedge clk); #1;
        in_valid = 1'b0;
        op(F_MFLO, 32'h0, 32'h0, 32'h0, 32'h1234_5678);

        // SUB at full rate during busy
        op_nores(F_MULTU, 32'h0);
        mul_hi = 32'hCAFE_0000; mul_lo = 32'h0000_CAFE;
        for (int i = 0; i < 4; i++)
            op(F_SUB, 32'h0000_0100 + 32'(i), 32'h0, 32'h0, 32'h0000_0100 + 32'(i));
        op(F_MFHI, 32'h0, 32'h0, 32'h0, 32'hCAFE_0000);
        op(F_MFLO, 32'h0, 32'h0, 32'h0, 32'h0000_CAFE);

        // Reset in busy cycle 2 aborts the multiply
        op_nores(F_MULTU, 32'h0);
        idle(1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy_before", {31'b0, busy}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0; mul_hi = 32'hAAAA_AAAA; mul_lo = 32'hAAAA_AAAA;
        @(negedge clk);
        chk("abort_busy_after", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        idle(3);
        op(F_MFLO, 32'h0, 32'h0, 32'h0, 32'h0);
        op(F_MFHI, 32'h0, 32'h0, 32'h0, 32'h0);

`ifdef RESULT_MUX_MTHI_EN
        op_nores(F_MTLO, 32'h0000_0055);
        op(F_MFLO, 32'h0, 32'h0, 32'h0, 32'h0000_0055);
        op_nores(F_MTHI, 32'h0000_0077);
        op(F_MFHI, 32'h0, 32'h0, 32'h0, 32'h0000_0077);
`else
        op(F_MTHI, 32'h0000_0077, 32'h0, 32'h0000_0099, 32'h0);
        op(F_MTLO, 32'h0000_0077, 32'h0, 32'h0000_0099, 32'h0);
        op(F_MFLO, 32'h0, 32'h0, 32'h0, 32'h0);
`endif

        idle(3);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
